load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, default 6, word-index width driven to the data memory (64 words).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req  in  1  access request; sampled only when busy=0.
REQ-005 is_store  in  1  1=store, 0=load; sampled with req.
REQ-006 funct3  in  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW.
REQ-007 addr  in  32  byte address; sampled with req.
REQ-008 wdata  in  32  store data, right-aligned; sampled with req.
REQ-009 busy  out  1  high whenever the state is not IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  valid with done; 1 = misaligned or illegal funct3, no memory access made.
REQ-012 rdata  out  32  load result, extended to 32 bits; holds until the next successful load.
REQ-013 mem_read  out  1  memory read enable.
REQ-014 mem_write  out  1  memory write enable; memory commits on the rising edge.
REQ-015 mem_addr  out  ADDR_W  word index = captured addr[ADDR_W+1:2]; upper bits ignored, so addresses wrap.
REQ-016 mem_wdata  out  32  full word to write.
REQ-017 mem_rdata  in  32  word read combinationally from memory at mem_addr while mem_read=1.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, RD, WR and RESP.
REQ-019 In IDLE with req=1, the unit SHALL capture is_store, funct3, addr and wdata.
REQ-020 On capture, a halfword access with addr[0]=1 SHALL be an error.
REQ-021 On capture, a word access with addr[1:0]!=00 SHALL be an error.
REQ-022 On capture, load funct3 011/110/111 and store funct3 other than 000/001/010 SHALL be errors.
REQ-023 Transitions from IDLE on req SHALL be: error -> RESP; load -> RD; SW -> WR; SB/SH -> RD.
REQ-024 Transitions from RD SHALL be: load -> RESP; SB/SH -> WR. From WR -> RESP. From RESP -> IDLE.
REQ-025 mem_read SHALL be 1 only in RD; mem_write SHALL be (state==WR) AND rst_n; both SHALL be 0 in all other states.
REQ-026 Load: at the end of RD, the unit SHALL select the lane from mem_rdata and register it into rdata.
REQ-027 Load lane selection: byte = addr[1:0]*8, halfword = addr[1]*16.
REQ-028 Load extension: LB/LH sign-extend; LBU/LHU zero-extend.
REQ-029 SB/SH: the unit SHALL register mem_rdata in RD, then in WR drive mem_wdata = that word with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
REQ-030 SW: mem_wdata SHALL equal wdata in WR.
REQ-031 done SHALL be 1 only in RESP; err SHALL be 1 only in RESP for an error access.
REQ-032 rdata SHALL be unchanged by stores and by erroring accesses.
REQ-033 Latency from the req-sampling edge t: load and SW done at cycle t+2; SB/SH done at t+3; error done at t+1.
REQ-034 req while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-035 req held high continuously SHALL start a new access on the cycle after RESP.
REQ-036 mem_addr and mem_wdata SHALL be 0 while IDLE.

Reset
REQ-037 When rst_n=0 at a rising edge: state=IDLE; busy, done, err = 0; rdata = 0; all captured registers = 0.
REQ-038 Because mem_write is gated by rst_n, reset asserted during WR SHALL commit no write.
REQ-039 An access interrupted by reset SHALL produce no done pulse.

Verification
REQ-040 Memory words 0/1/2 preloaded 17/9/25; LW addr 0x8 -> mem_read in RD, done at t+2, rdata=25, err=0.
REQ-041 SW addr 0x4 wdata 0x800080F0, then LB addr 0x5 -> rdata 0xFFFFFF80; LBU addr 0x5 -> 0x00000080; LHU addr 0x6 -> 0x00008000.
REQ-042 SB addr 0x2 wdata 0x123456AB onto word0=0x00000011 -> RD at t+1, WR at t+2 with mem_wdata 0x00AB0011, done at t+3; LW addr 0x0 -> 0x00AB0011.
REQ-043 LH addr 0x1, and SW addr 0x6 -> done and err at t+1; mem_read and mem_write never asserted; rdata unchanged.
REQ-044 SH addr 0x0 wdata 0xBEEF with rst_n driven 0 during the WR cycle -> no write, word0 unchanged, busy=0, no done.
REQ-045 req held high through a LW -> second request not sampled before RESP; next access starts the cycle after RESP.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-ported word memory.
// Handles byte/halfword/word loads with sign or zero extension, and byte/halfword
// stores via read-modify-write. Misaligned or illegal accesses complete with err
// and never touch memory.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req, is_store, funct3      access request, direction and size/extension code
//   addr, wdata                byte address and right-aligned store data
//   busy, done, err            not-idle flag, completion pulse, error with done
//   rdata                      last successful load result
//   mem_read, mem_write        memory enables
//   mem_addr, mem_wdata        memory word index and write word
//   mem_rdata                  combinational memory read word
module load_store_unit #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e             state_q;
  logic               is_store_q;
  logic [2:0]         funct3_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        word_q;
  logic               err_q;
  logic [31:0]        rdata_q;

  logic               req_err;
  logic [31:0]        lane;
  logic [31:0]        load_val;
  logic [31:0]        merged;

  // Address bits above the memory index are dropped, so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // Alignment and funct3 legality of the incoming request.
  always_comb begin
    req_err = 1'b0;
    if (is_store) begin
      case (funct3)
        3'b000:  req_err = 1'b0;
        3'b001:  req_err = addr[0];
        3'b010:  req_err = |addr[1:0];
        default: req_err = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b100: req_err = 1'b0;
        3'b001, 3'b101: req_err = addr[0];
        3'b010:         req_err = |addr[1:0];
        default:        req_err = 1'b1;
      endcase
    end
  end

  // Shift the addressed lane down to bit 0, then extend.
  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'd0, lane[7:0]};
      3'b101:  load_val = {16'd0, lane[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  // Sub-word store: replace only the addressed lane of the word read in RD.
  always_comb begin
    merged = word_q;
    if (funct3_q[0]) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      word_q     <= 32'd0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            addr_q     <= addr[ADDR_W+1:0];
            wdata_q    <= wdata;
            err_q      <= req_err;
            if (req_err) begin
              state_q <= StResp;
            end else if (is_store && funct3 == 3'b010) begin
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          if (is_store_q) begin
            word_q  <= mem_rdata;
            state_q <= StWr;
          end else begin
            rdata_q <= load_val;
            state_q <= StResp;
          end
        end
        StWr:    state_q <= StResp;
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StResp);
  assign err       = (state_q == StResp) && err_q;
  assign rdata     = rdata_q;
  assign mem_read  = (state_q == StRd);
  // Gating with rst_n keeps a reset during WR from committing a write.
  assign mem_write = (state_q == StWr) && rst_n;
  assign mem_addr  = (state_q == StIdle) ? '0 : addr_q[ADDR_W+1:2];
  assign mem_wdata = (state_q != StWr) ? 32'd0 : (funct3_q[1] ? wdata_q : merged);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        preload;
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] ref_rdata;

  int tests;
  int fails;

  load_store_unit #(.ADDR_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on rising edge.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= (i == 0) ? 32'd17 : (i == 1) ? 32'd9 : (i == 2) ? 32'd25 : 32'd0;
      end
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed view of the memory using plain arithmetic.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic e, output int lat,
                       output logic rd_seen, output logic wr_seen, output logic [31:0] nw);
    int unsigned idx;
    int unsigned size;
    logic [31:0] mask;
    logic [31:0] word;
    logic [31:0] v;
    int unsigned sh;
    idx  = (a / 4) % 64;
    size = 4;
    e    = 1'b0;
    if (st) begin
      if (f3 > 3'd2) e = 1'b1;
      else size = 1 << f3;
    end else begin
      case (f3)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2:       size = 4;
        default:    e = 1'b1;
      endcase
    end
    if (!e && (a % size) != 0) e = 1'b1;
    word = ref_mem[idx];
    mask = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    sh   = (a % 4) * 8;
    nw   = word;
    if (e) begin
      lat = 1; rd_seen = 1'b0; wr_seen = 1'b0;
    end else if (!st) begin
      lat = 2; rd_seen = 1'b1; wr_seen = 1'b0;
      v = (word >> sh) & mask;
      if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~mask;
      ref_rdata = v;
    end else begin
      lat = (size == 4) ? 2 : 3;
      rd_seen = (size < 4);
      wr_seen = 1'b1;
      nw = (word & ~(mask << sh)) | ((wd & mask) << sh);
      ref_mem[idx] = nw;
    end
  endtask

  // One access on the DUT; expected err/latency/rdata come from the table when
  // use_tbl is set, otherwise from the model.
  task automatic run_one(input int tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic use_tbl,
                         input logic t_err, input int t_lat, input logic [31:0] t_rd);
    logic m_err, m_rd, m_wr, seen_rd, seen_wr, got_err;
    int m_lat, lat;
    logic [31:0] m_nw, wword;
    int unsigned idx;
    idx = (a / 4) % 64;
    model(st, f3, a, wd, m_err, m_lat, m_rd, m_wr, m_nw);
    @(negedge clk);
    req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'd0; wdata = 32'd0;
    lat = 1; seen_rd = 1'b0; seen_wr = 1'b0; wword = 32'd0;
    while (!done && lat < 10) begin
      seen_rd |= mem_read;
      if (mem_write) begin
        seen_wr = 1'b1;
        wword = mem_wdata;
      end
      @(posedge clk); #1;
      lat++;
    end
    got_err = err;
    check($sformatf("v%0d latency", tag), 32'(lat), use_tbl ? 32'(t_lat) : 32'(m_lat));
    check($sformatf("v%0d err", tag), {31'd0, got_err}, {31'd0, use_tbl ? t_err : m_err});
    check($sformatf("v%0d rdata", tag), rdata, use_tbl ? t_rd : ref_rdata);
    check($sformatf("v%0d mem_read seen", tag), {31'd0, seen_rd}, {31'd0, m_rd});
    check($sformatf("v%0d mem_write seen", tag), {31'd0, seen_wr}, {31'd0, m_wr});
    if (m_wr) check($sformatf("v%0d mem_wdata", tag), wword, m_nw);
    @(posedge clk); #1;
    check($sformatf("v%0d idle busy", tag), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d single done", tag), {31'd0, done}, 32'd0);
    check($sformatf("v%0d idle mem_addr", tag), {26'd0, mem_addr}, 32'd0);
    check($sformatf("v%0d idle mem_wdata", tag), mem_wdata, 32'd0);
    check($sformatf("v%0d mem word", tag), mem[idx], ref_mem[idx]);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        e;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic m_err, m_rd, m_wr;
    int m_lat, dcount;
    logic [31:0] m_nw, a;
    logic [2:0] f3;
    logic st;

    tests = 0; fails = 0;
    tbl[0]  = '{st: 1'b0, f3: 3'b010, a: 32'h8, wd: 32'h0,          e: 1'b0, lat: 2, rd: 32'd25};
    tbl[1]  = '{st: 1'b1, f3: 3'b010, a: 32'h4, wd: 32'h800080F0,   e: 1'b0, lat: 2, rd: 32'd25};
    tbl[2]  = '{st: 1'b0, f3: 3'b000, a: 32'h5, wd: 32'h0,          e: 1'b0, lat: 2, rd: 32'hFFFFFF80};
    tbl[3]  = '{st: 1'b0, f3: 3'b100, a: 32'h5, wd: 32'h0,          e: 1'b0, lat: 2, rd: 32'h00000080};
    tbl[4]  = '{st: 1'b0, f3: 3'b101, a: 32'h6, wd: 32'h0,          e: 1'b0, lat: 2, rd: 32'h00008000};
    tbl[5]  = '{st: 1'b1, f3: 3'b000, a: 32'h2, wd: 32'h123456AB,   e: 1'b0, lat: 3, rd: 32'h00008000};
    tbl[6]  = '{st: 1'b0, f3: 3'b010, a: 32'h0, wd: 32'h0,          e: 1'b0, lat: 2, rd: 32'h00AB0011};
    tbl[7]  = '{st: 1'b0, f3: 3'b001, a: 32'h1, wd: 32'h0,          e: 1'b1, lat: 1, rd: 32'h00AB0011};
    tbl[8]  = '{st: 1'b1, f3: 3'b010, a: 32'h6, wd: 32'hDEADBEEF,   e: 1'b1, lat: 1, rd: 32'h00AB0011};
    tbl[9]  = '{st: 1'b0, f3: 3'b011, a: 32'h0, wd: 32'h0,          e: 1'b1, lat: 1, rd: 32'h00AB0011};
    tbl[10] = '{st: 1'b1, f3: 3'b100, a: 32'h0, wd: 32'h55555555,   e: 1'b1, lat: 1, rd: 32'h00AB0011};

    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = (i == 0) ? 32'd17 : (i == 1) ? 32'd9 : (i == 2) ? 32'd25 : 32'd0;
    end
    ref_rdata = 32'd0;

    preload = 1'b1; rst_n = 1'b0; req = 1'b0; is_store = 1'b0;
    funct3 = 3'b000; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset mem_read", {31'd0, mem_read}, 32'd0);
    check("reset mem_write", {31'd0, mem_write}, 32'd0);
    check("reset mem_addr", {26'd0, mem_addr}, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    preload = 1'b0; rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_one(i, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, 1'b1, tbl[i].e, tbl[i].lat, tbl[i].rd);
    end

    // Reset asserted during the WR cycle of an SH: no write, no done.
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = 3'b001; addr = 32'h0; wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    req = 1'b0; is_store = 1'b0; funct3 = 3'b000; wdata = 32'd0;
    check("rstwr RD mem_read", {31'd0, mem_read}, 32'd1);
    @(posedge clk); #1;
    check("rstwr WR mem_write", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstwr gated mem_write", {31'd0, mem_write}, 32'd0);
    @(posedge clk); #1;
    check("rstwr busy", {31'd0, busy}, 32'd0);
    check("rstwr word0", mem[0], ref_mem[0]);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("rstwr no done", 32'(dcount), 32'd0);
    ref_rdata = 32'd0;
    check("rstwr rdata cleared", rdata, 32'd0);

    // req held high through a LW: not resampled in RESP, restarts right after.
    model(1'b0, 3'b010, 32'h8, 32'd0, m_err, m_lat, m_rd, m_wr, m_nw);
    model(1'b0, 3'b010, 32'h8, 32'd0, m_err, m_lat, m_rd, m_wr, m_nw);
    @(negedge clk);
    req = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h8;
    @(posedge clk); #1;
    check("hold RD", {31'd0, mem_read}, 32'd1);
    @(posedge clk); #1;
    check("hold first done", {31'd0, done}, 32'd1);
    check("hold first rdata", rdata, 32'd25);
    @(posedge clk); #1;
    check("hold idle gap busy", {31'd0, busy}, 32'd0);
    check("hold idle gap done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check("hold restart RD", {31'd0, mem_read}, 32'd1);
    req = 1'b0;
    @(posedge clk); #1;
    check("hold second done", {31'd0, done}, 32'd1);
    check("hold second rdata", rdata, ref_rdata);
    @(posedge clk); #1;
    check("hold final idle", {31'd0, busy}, 32'd0);

    // Randomized accesses against the model.
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
        if (!st && f3 == 3'd3) f3 = 3'd4;
      end else begin
        f3 = 3'($urandom);
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      else if ($urandom_range(0, 1) == 0) a[0] = 1'b0;
      run_one(100 + n, st, f3, a, $urandom, 1'b0, 1'b0, 0, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
